// File: rtl/ecc_sed_pkg.sv
// Shared types and constants for the single-error-detect (SED) parity receive path.
package ecc_sed_pkg;

    localparam int ECC_SED_DATA_W  = 12;
    localparam int ECC_SED_CW_W    = 13;
    localparam int ECC_SED_PAR_POS = 12;

    typedef enum logic [1:0] {
        HEALTHY  = 2'd0,
        DEGRADED = 2'd1,
        ALARM    = 2'd2
    } ecc_sed_health_e;

endpackage

// File: rtl/ecc_sed_parity_check.sv
// Even-parity syndrome generator for a SED codeword; a 1 means the word is corrupt.
module ecc_sed_parity_check
    import ecc_sed_pkg::*;
#(
    parameter int CW_W = ECC_SED_CW_W
) (
    input  logic [CW_W-1:0] codeword,
    output logic            syndrome
);

    assign syndrome = ^codeword;

endmodule

// File: rtl/ecc_sed_decoder.sv
// SED receive stage: parity check, one-cycle data forwarding and error statistics.
// Optional feature macro ECC_SED_DEC_LAST_ERR_EN adds last_err_word, a capture
// of the most recent errored codeword.
//
// state    | meaning
// HEALTHY  | no errors in the current run of valid words
// DEGRADED | errored run in progress, below BURST_THRESH
// ALARM    | BURST_THRESH consecutive errors seen; held until err_clear
module ecc_sed_decoder
    import ecc_sed_pkg::*;
#(
    parameter int DATA_WIDTH   = ECC_SED_DATA_W,
    parameter int CNT_WIDTH    = 8,
    parameter int BURST_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enc_valid,
    input  logic [DATA_WIDTH:0]   enc_codeword,
    input  logic                  err_clear,
    output logic                  dec_valid,
    output logic [DATA_WIDTH-1:0] dec_data,
    output logic                  dec_err,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  burst_alarm
`ifdef ECC_SED_DEC_LAST_ERR_EN
    ,
    output logic [DATA_WIDTH:0]   last_err_word
`endif
);

    // Burst counter only needs to reach BURST_THRESH, which is at most 15.
    localparam logic [3:0] BURST_MAX = 4'(BURST_THRESH);
    localparam ecc_sed_health_e FIRST_ERR_STATE = (BURST_THRESH == 1) ? ALARM : DEGRADED;

    logic syndrome;
    logic err_word;

    ecc_sed_parity_check #(.CW_W(DATA_WIDTH + 1)) u_parity (
        .codeword (enc_codeword),
        .syndrome (syndrome)
    );

    assign err_word = enc_valid & syndrome;

    logic                  dec_valid_q,   dec_valid_d;
    logic [DATA_WIDTH-1:0] dec_data_q,    dec_data_d;
    logic                  dec_err_q,     dec_err_d;
    logic                  err_sticky_q,  err_sticky_d;
    logic [CNT_WIDTH-1:0]  err_count_q,   err_count_d;
    logic [3:0]            burst_cnt_q,   burst_cnt_d;
    ecc_sed_health_e       state_q,       state_d;
    logic                  burst_alarm_q, burst_alarm_d;

    // Next-state for the data path, statistics and health FSM.
    always_comb begin
        dec_valid_d  = enc_valid;
        dec_data_d   = enc_valid ? enc_codeword[DATA_WIDTH-1:0] : dec_data_q;
        dec_err_d    = err_word;
        err_sticky_d = err_sticky_q | err_word;
        err_count_d  = err_count_q;
        burst_cnt_d  = burst_cnt_q;
        state_d      = state_q;

        if (err_word && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end

        if (enc_valid) begin
            if (err_word) begin
                burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = 4'd0;
            end
            if (state_q != ALARM) begin
                if (!err_word) begin
                    state_d = HEALTHY;
                end else if (burst_cnt_d >= BURST_MAX) begin
                    state_d = ALARM;
                end else begin
                    state_d = DEGRADED;
                end
            end
        end

        // A word that errors in the clear cycle starts a fresh run.
        if (err_clear) begin
            err_sticky_d = err_word;
            err_count_d  = CNT_WIDTH'(err_word);
            burst_cnt_d  = {3'd0, err_word};
            state_d      = err_word ? FIRST_ERR_STATE : HEALTHY;
        end

        burst_alarm_d = (state_d == ALARM);
    end

    // Register all outputs and the FSM with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid_q   <= 1'b0;
            dec_data_q    <= '0;
            dec_err_q     <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_count_q   <= '0;
            burst_cnt_q   <= 4'd0;
            state_q       <= HEALTHY;
            burst_alarm_q <= 1'b0;
        end else begin
            dec_valid_q   <= dec_valid_d;
            dec_data_q    <= dec_data_d;
            dec_err_q     <= dec_err_d;
            err_sticky_q  <= err_sticky_d;
            err_count_q   <= err_count_d;
            burst_cnt_q   <= burst_cnt_d;
            state_q       <= state_d;
            burst_alarm_q <= burst_alarm_d;
        end
    end

    assign dec_valid   = dec_valid_q;
    assign dec_data    = dec_data_q;
    assign dec_err     = dec_err_q;
    assign err_sticky  = err_sticky_q;
    assign err_count   = err_count_q;
    assign burst_alarm = burst_alarm_q;

`ifdef ECC_SED_DEC_LAST_ERR_EN
    logic [DATA_WIDTH:0] last_err_word_q, last_err_word_d;

    // Capture the most recent errored codeword; err_clear leaves it alone.
    always_comb begin
        last_err_word_d = err_word ? enc_codeword : last_err_word_q;
    end

    // Register the captured codeword.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_err_word_q <= '0;
        end else begin
            last_err_word_q <= last_err_word_d;
        end
    end

    assign last_err_word = last_err_word_q;
`endif

endmodule
